filter_pixel_accum: RTL
=======================

# filter_pixel_accum

Downstream stage of the vector ALU in the filter GPU datapath. Consumes one horizontal-sum result per kernel row (ALU lane 0 with the reduce operation), accumulates KROWS rows per output pixel, and normalises by an arithmetic right shift. Clamps the result to an unsigned pixel and presents it on a valid/ready output port. Back-pressures the ALU issue logic while a finished pixel is unconsumed.

## Interface
- N, 18, ALU lane width; lane results are signed two's complement.
- V, 3, ALU lane count; only lane 0 is consumed.
- KROWS, 3, rows accumulated per pixel (2..7).
- SHIFT, 4, normalisation right-shift amount (0..N-1).
- PIX_W, 8, output pixel width.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  block accepts a row this cycle.
- in_result  in  [V-1:0][N-1:0]  ALU Result vector; lane 0 holds the row sum.
- in_flags  in  4  ALU flags {overflow, carry, zero, negative}.
- flush  in  1  discard the partial pixel (synchronous).
- out_valid  out  1  pixel available.
- out_ready  in  1  consumer takes the pixel.
- out_pixel  out  PIX_W  clamped, normalised pixel.
- out_sat  out  1  clamp was applied to this pixel.
- out_ovf  out  1  an ALU overflow occurred in any row of this pixel.

## Operation
- Accumulator acc is signed, N+3 bits wide, so it cannot overflow for KROWS ≤ 7.
- Row counter cnt runs from 0 to KROWS-1.
- Sticky ovf_acc.
- Row accept: in_valid && in_ready. On accept, acc += sign-extended in_result[0] and cnt increments.
- Last row: on accept with cnt == KROWS-1:
  - sum = acc + row.
  - norm = sum >>> SHIFT (arithmetic, rounds toward −inf).
  - out_pixel = 0 if norm < 0; 2^PIX_W−1 if norm > 2^PIX_W−1; otherwise norm.
  - out_sat = 1 iff clamped.
  - out_ovf = ovf_acc | in_flags[3].
  - out_valid is set.
  - acc, cnt and ovf_acc are cleared in the same cycle.
- in_ready = !(out_valid && !out_ready). A pixel being consumed this cycle does not stall input.
- out_valid is cleared on out_ready unless a new last row is accepted in the same cycle; in that case it stays 1 and the output loads the new pixel.
- flush clears acc, cnt and ovf_acc and blocks acceptance that cycle (in_ready = 0). It does not affect a held output pixel.
- Lanes 1..V-1 and in_flags[2:0] are ignored.
- FSM states:
  - ACC: out_valid = 0; rows accepted.
  - HOLD: out_valid = 1 and out_ready = 0; in_ready = 0.
  - The ACC/HOLD distinction is equivalent to out_valid and needs no extra state register.
- Reset values: out_valid = 0, out_pixel = 0, out_sat = 0, out_ovf = 0, acc = 0, cnt = 0, ovf_acc = 0. in_ready = 1 in the cycle after reset deasserts.
- Reset mid-pixel discards the partial sum and any held pixel.

## Timing
- Latency: 1 cycle from the accept of the last row to out_valid = 1 with the pixel registered.
- Throughput: one row per cycle; one pixel per KROWS cycles with out_ready held high.
- in_ready depends combinationally on out_valid, out_ready and flush only. There is no path from in_valid.
- Outputs change only on the rising edge of clk.
- Simultaneous flush and in_valid: the row is dropped and in_ready = 0.
- Simultaneous out_ready and a last-row accept: the old pixel is consumed and the new one is loaded on the next edge.

## Configuration
- FILTER_ACC_OVF_EN defined: ovf_acc tracking is implemented and out_ovf behaves as described.
- FILTER_ACC_OVF_EN not defined: ovf_acc is not built, in_flags is ignored entirely, and out_ovf is tied to 0.

## Test plan
All scenarios use default parameters.
- Rows 16, 32, 48 with out_ready = 1: one cycle after the third accept, out_valid = 1, out_pixel = 6, out_sat = 0.
- Rows −100, −20, 10: out_pixel = 0, out_sat = 1. Rows 4000, 4000, 4000: out_pixel = 255, out_sat = 1.
- Back-pressure: two pixels streamed with out_ready = 0. in_ready drops the cycle after the first pixel. The first pixel is held unchanged until out_ready = 1. The second pixel (rows 160 ×3 → 30) follows with no lost rows.
- Flush after two rows of 100, then rows 16, 16, 16: out_pixel = 3. The flushed rows do not contribute.
- With FILTER_ACC_OVF_EN defined, in_flags = 4'b1000 on row 2: out_ovf = 1 for that pixel and 0 for the next. With the macro undefined, out_ovf = 0.
- Reset (rst_n = 0 for one cycle) after one row, and again while holding a pixel: out_valid = 0, in_ready = 1 afterwards, and the next three rows of 16 give out_pixel = 3.

Source files
------------

// File: rtl/filter_pixel_accum_if.sv
// Row-input / pixel-output bundle between the vector ALU reduce lane and the pixel accumulator.
// slave is the accumulator side; master is the ALU issue logic plus the pixel consumer.
interface filter_pixel_accum_if #(
  parameter int unsigned N     = 18,
  parameter int unsigned V     = 3,
  parameter int unsigned PIX_W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [V-1:0][N-1:0]   in_result;
  logic [3:0]            in_flags;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [PIX_W-1:0]      out_pixel;
  logic                  out_sat;
  logic                  out_ovf;

  modport slave (
    input  in_valid, in_result, in_flags, flush, out_ready,
    output in_ready, out_valid, out_pixel, out_sat, out_ovf
  );

  modport master (
    output in_valid, in_result, in_flags, flush, out_ready,
    input  in_ready, out_valid, out_pixel, out_sat, out_ovf
  );
endinterface

// File: rtl/filter_pixel_accum.sv
// Accumulates KROWS ALU row sums per pixel, normalises by >>> SHIFT and clamps to PIX_W bits.
// Optional macro FILTER_ACC_OVF_EN enables sticky ALU-overflow tracking on out_ovf.
module filter_pixel_accum #(
  parameter int unsigned N     = 18,
  parameter int unsigned V     = 3,
  parameter int unsigned KROWS = 3,
  parameter int unsigned SHIFT = 4,
  parameter int unsigned PIX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  filter_pixel_accum_if.slave   bus
);
  localparam int unsigned AW = N + 3;
  localparam int unsigned CW = 3;

  logic signed [AW-1:0] r_acc;
  logic [CW-1:0]        r_cnt;
  logic signed [AW-1:0] w_row;
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_norm;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_neg;
  logic                 w_big;
  logic [PIX_W-1:0]     w_pix;
  logic                 w_ovf_pix;
  logic                 w_unused;

  // Output state doubles as the ACC/HOLD state: holding stalls the ALU.
  assign bus.in_ready = !bus.flush && !(bus.out_valid && !bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_last       = w_accept && (r_cnt == CW'(KROWS - 1));

  assign w_row  = {{(AW-N){bus.in_result[0][N-1]}}, bus.in_result[0]};
  assign w_sum  = r_acc + w_row;
  assign w_norm = w_sum >>> SHIFT;
  assign w_neg  = w_norm[AW-1];
  assign w_big  = |w_norm[AW-2:PIX_W];
  assign w_pix  = w_neg ? '0 : (w_big ? '1 : w_norm[PIX_W-1:0]);

`ifdef FILTER_ACC_OVF_EN
  logic r_ovf_acc;

  assign w_ovf_pix = r_ovf_acc | bus.in_flags[3];
  assign w_unused  = ^{bus.in_result[V-1:1], bus.in_flags[2:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_acc <= 1'b0;
    end else if (bus.flush || w_last) begin
      r_ovf_acc <= 1'b0;
    end else if (w_accept) begin
      r_ovf_acc <= w_ovf_pix;
    end
  end
`else
  assign w_ovf_pix = 1'b0;
  assign w_unused  = ^{bus.in_result[V-1:1], bus.in_flags};
`endif

  // Row accumulation; the last row both closes the pixel and restarts the sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (bus.flush || w_last) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Pixel register: a consumed pixel is replaced if a new one lands the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_pixel <= '0;
      bus.out_sat   <= 1'b0;
      bus.out_ovf   <= 1'b0;
    end else if (w_last) begin
      bus.out_valid <= 1'b1;
      bus.out_pixel <= w_pix;
      bus.out_sat   <= w_neg | w_big;
      bus.out_ovf   <= w_ovf_pix;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
